// File: rtl/piso_shiftreg_tx_pkg.sv
// Shared definitions for serial transmit/receive blocks.
package piso_shiftreg_tx_pkg;

  localparam int unsigned PISO_N_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_shiftreg_tx.sv
// Parallel-in serial-out transmitter, LSB first, with a one-cycle done pulse.
//   state | meaning
//   IDLE  | ready for a new word, sout held low
//   SHIFT | frame in flight, one bit per cycle with EN high
module piso_shiftreg_tx
  import piso_shiftreg_tx_pkg::*;
#(
  parameter int N = PISO_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         load,
  input  logic         EN,
  output logic         ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  piso_state_e      state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // load is deliberately ignored here; only EN advances the frame
        if (EN) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            shreg_d = {1'b0, shreg_q[N-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready      = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign sout       = (state_q == SHIFT) ? shreg_q[0] : 1'b0;
  assign sout_valid = (state_q == SHIFT) && EN;
  assign done       = done_q;

endmodule
